// File: rtl/reduce_unit_pipe.sv
// Three-stage pipelined N-bit reduction (OR/AND/XOR/NOR) with valid/ready flow
// control and a saturating counter of 1-results.
module reduce_unit_pipe #(
  parameter int WIDTH   = 8,
  parameter int GROUPS  = 2,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_result,
  output logic [1:0]         out_mode,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] hit_count
);

  localparam int SLICE_W = WIDTH / GROUPS;
  localparam logic [1:0] MODE_OR  = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_NOR = 2'b11;
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  if ((WIDTH < 2) || (GROUPS < 1) || ((WIDTH % GROUPS) != 0)) begin : g_bad_params
    $error("reduce_unit_pipe: WIDTH must be >= 2 and a multiple of GROUPS");
  end

  // NOR reduces with OR here; the inversion happens once, in stage C.
  function automatic logic slice_reduce(input logic [SLICE_W-1:0] bits_s,
                                        input logic [1:0]         mode_s);
    logic red_s;
    case (mode_s)
      MODE_AND:          red_s = &bits_s;
      MODE_XOR:          red_s = ^bits_s;
      MODE_OR, MODE_NOR: red_s = |bits_s;
      default:           red_s = |bits_s;
    endcase
    return red_s;
  endfunction

  function automatic logic group_reduce(input logic [GROUPS-1:0] bits_s,
                                        input logic [1:0]        mode_s);
    logic red_s;
    case (mode_s)
      MODE_AND:          red_s = &bits_s;
      MODE_XOR:          red_s = ^bits_s;
      MODE_OR, MODE_NOR: red_s = |bits_s;
      default:           red_s = |bits_s;
    endcase
    return red_s;
  endfunction

  logic              va_r, vb_r, vc_r;
  logic [WIDTH-1:0]  da_r;
  logic [1:0]        ma_r, mb_r, mc_r;
  logic [GROUPS-1:0] pb_r;
  logic              res_r;
  logic [COUNT_W-1:0] hit_r;

  logic              adv_a_s, adv_b_s, adv_c_s;
  logic [GROUPS-1:0] part_s;
  logic              final_s;

  // Backpressure chain: an empty or draining stage may accept new data.
  always_comb begin
    adv_c_s = 1'b0;
    adv_b_s = 1'b0;
    adv_a_s = 1'b0;
    adv_c_s = !vc_r | out_ready;
    adv_b_s = !vb_r | adv_c_s;
    adv_a_s = !va_r | adv_b_s;
  end

  // Per-slice partial reductions of the stage A operand.
  always_comb begin
    part_s = {GROUPS{1'b0}};
    for (int g = 0; g < GROUPS; g++) begin
      part_s[g] = slice_reduce(da_r[g*SLICE_W +: SLICE_W], ma_r);
    end
  end

  // Combine the partials and apply the NOR inversion.
  always_comb begin
    final_s = 1'b0;
    if (mb_r == MODE_NOR) begin
      final_s = !group_reduce(pb_r, mb_r);
    end else begin
      final_s = group_reduce(pb_r, mb_r);
    end
  end

  // Stage A: capture operand and mode only on an input transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      va_r <= 1'b0;
      da_r <= {WIDTH{1'b0}};
      ma_r <= 2'b00;
    end else if (adv_a_s) begin
      va_r <= in_valid;
      if (in_valid) begin
        da_r <= in_data;
        ma_r <= in_mode;
      end
    end
  end

  // Stage B: register slice partials.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vb_r <= 1'b0;
      pb_r <= {GROUPS{1'b0}};
      mb_r <= 2'b00;
    end else if (adv_b_s) begin
      vb_r <= va_r;
      if (va_r) begin
        pb_r <= part_s;
        mb_r <= ma_r;
      end
    end
  end

  // Stage C: register the final bit; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vc_r  <= 1'b0;
      res_r <= 1'b0;
      mc_r  <= 2'b00;
    end else if (adv_c_s) begin
      vc_r <= vb_r;
      if (vb_r) begin
        res_r <= final_s;
        mc_r  <= mb_r;
      end
    end
  end

  // Saturating count of accepted 1-results; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_r <= {COUNT_W{1'b0}};
    end else if (cnt_clr) begin
      hit_r <= {COUNT_W{1'b0}};
    end else if (vc_r && out_ready && res_r && (hit_r != CNT_MAX)) begin
      hit_r <= hit_r + CNT_ONE;
    end
  end

  assign in_ready   = adv_a_s & rst_n;
  assign out_valid  = vc_r;
  assign out_result = res_r;
  assign out_mode   = mc_r;
  assign hit_count  = hit_r;

endmodule
